mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between execute and write-back. Accepts one instruction per handshake from execute and performs word loads and stores on a req/gnt/rvalid data-memory bus. It stalls upstream while a bus transaction is outstanding, then presents registered results to the write-back data selector: ALU result, operand 2, opcode, and load data as `mem_out`.

## Interface
- `TIMEOUT_CYC`, default 255: maximum cycles spent in REQ+RESP before abort; 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: execute presents an instruction.
- `ex_opcode` in 6: opcode; encodings from instr_syntax.v.
- `ex_alu_out` in 32: ALU result; effective address for LD/ST.
- `ex_oprand2` in 32: operand 2; store data for ST, move data for MOV*.
- `stall` out 1: execute must hold its outputs.
- `dm_req` out 1: bus request.
- `dm_we` out 1: 1 = store, 0 = load.
- `dm_addr` out 32: word address, byte-addressed, [1:0] = 0.
- `dm_wdata` out 32: store data.
- `dm_gnt` in 1: bus accepted the request this cycle.
- `dm_rvalid` in 1: load data valid this cycle.
- `dm_rdata` in 32: load data.
- `wb_valid` out 1: write-back fields valid for one cycle.
- `wb_opcode` out 6: opcode of the retiring instruction.
- `wb_alu_out` out 32: registered ALU result.
- `wb_oprand2` out 32: registered operand 2.
- `mem_out` out 32: load data; 0 for non-loads.
- `mem_err` out 1: one-cycle pulse with `wb_valid` on misaligned or timed-out LD/ST.

## Operation
- FSM states: IDLE, REQ, RESP.
- Accept means `ex_valid` sampled high in IDLE. `stall` = (state != IDLE). In IDLE, `ex_valid` is always accepted.
- Non-memory opcode accepted: the next edge loads the wb fields, sets `wb_valid`=1 and `mem_out`=0. State stays IDLE.
- LD/ST accepted with `ex_alu_out[1:0]` != 0:
  - No bus access.
  - Next edge: `wb_valid`=1, `mem_err`=1, `mem_out`=0. State stays IDLE.
- LD/ST accepted and aligned:
  - Latch opcode, address and data. Go to REQ.
  - Clear the timeout counter.
- REQ:
  - `dm_req`=1. `dm_addr`, `dm_we` and `dm_wdata` are held stable until a grant is sampled.
  - `dm_gnt`=1 on ST: retire (`wb_valid`=1, `mem_out`=0) and go to IDLE.
  - `dm_gnt`=1 on LD: go to RESP. `dm_req` drops the next cycle.
- RESP:
  - `dm_req`=0.
  - `dm_rvalid`=1: `mem_out` ← `dm_rdata`, retire, go to IDLE.
  - `dm_rvalid` sampled in any state other than RESP is ignored.
- Timeout:
  - 16-bit counter increments each cycle in REQ/RESP.
  - When it reaches `TIMEOUT_CYC` without completion: retire with `mem_err`=1 and `mem_out`=0, go to IDLE.
  - A grant or rvalid arriving in that same cycle takes priority over the timeout.
- `wb_valid` and `mem_err` are single-cycle pulses. The wb data fields hold their value until the next retire.
- Reset at any time, including mid-transaction:
  - Asynchronously forces IDLE and drops `dm_req`.
  - Every output reads 0, including `dm_addr`, `dm_wdata` and all wb fields.
  - `stall` reads 0.
  - Any outstanding transaction is abandoned; no retire is generated.

## Timing
- Non-memory op or misaligned LD/ST: accepted at edge N, `wb_valid` high in cycle N+1. Throughput is 1 per cycle.
- Aligned op accepted at edge N:
  - `dm_req`=1 and `stall`=1 from cycle N+1.
  - ST with grant in cycle N+k: `wb_valid` in cycle N+k+1, `stall` low in N+k+1.
  - LD with grant in N+k and rvalid in N+m (m > k): `wb_valid` and `mem_out` in N+m+1.
  - Minimum load latency is 3 cycles from accept to `wb_valid`.
- All bus and wb outputs are registered; `stall` is decoded from the state register. No combinational path from bus inputs to any output.

## Test plan
- Reset, then ADDU with `ex_alu_out`=0x0000_1234:
  - All outputs 0 during reset.
  - One cycle after accept: `wb_valid`=1, `wb_alu_out`=0x1234, `mem_out`=0, `stall` never asserted.
- LD at 0x100:
  - `dm_req` with `dm_addr`=0x100, `dm_we`=0.
  - Grant after 2 wait cycles, rvalid 1 cycle after grant with 0xDEAD_BEEF.
  - Required: `mem_out`=0xDEAD_BEEF with `wb_valid`, `stall` high exactly during REQ/RESP, `dm_addr` stable throughout REQ.
- ST at 0x204 with `ex_oprand2`=0xA5A5_0001, immediate grant:
  - `dm_we`=1 and `dm_wdata`=0xA5A5_0001 for 1 cycle.
  - `wb_valid` on the next cycle, `mem_out`=0.
- LD at 0x102:
  - No `dm_req`.
  - Next cycle: `wb_valid`=1, `mem_err`=1, `mem_out`=0.
- `TIMEOUT_CYC`=4, LD never granted:
  - `dm_req` high for exactly 4 cycles.
  - Then `wb_valid`=`mem_err`=1 and state returns to IDLE; a following MOV retires normally.
- Assert `rst_n`=0 during RESP of a load:
  - `dm_req` and `stall` go low asynchronously.
  - A late `dm_rvalid` after reset is ignored; no `wb_valid` pulse.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage between execute and write-back. Accepts one instruction
// per cycle from execute. It performs aligned word loads and stores on a
// req/gnt/rvalid data-memory bus. Execute is stalled while a bus transaction
// is outstanding. Results are presented to the write-back selector as
// registered outputs.
//
// Parameters
//   TIMEOUT_CYC : maximum number of cycles spent in REQ+RESP before the
//                 access is aborted with mem_err (1..65535)
//   OP_LD/OP_ST : opcode encodings of the word load / word store
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   ex_valid            : execute presents an instruction
//   ex_opcode           : opcode of the presented instruction
//   ex_alu_out          : ALU result; effective address for LD/ST
//   ex_oprand2          : operand 2; store data for ST
//   stall               : execute must hold its outputs
//   dm_req/dm_we        : bus request, 1 = store / 0 = load
//   dm_addr/dm_wdata    : word address and store data
//   dm_gnt              : bus accepted the request this cycle
//   dm_rvalid/dm_rdata  : load data return
//   wb_valid            : write-back fields valid for one cycle
//   wb_opcode/wb_alu_out/wb_oprand2 : registered instruction fields
//   mem_out             : load data, 0 for non-loads
//   mem_err             : pulse with wb_valid on misaligned or timed-out LD/ST
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [5:0]  OP_LD       = 6'h23,
    parameter logic [5:0]  OP_ST       = 6'h2B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [5:0]  ex_opcode,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_oprand2,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [5:0]  wb_opcode,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_oprand2,
    output logic [31:0] mem_out,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t      state;

    // Fields of the in-flight memory instruction, retired to wb_* on completion.
    logic [5:0]  opc_p1;
    logic [31:0] alu_p1;
    logic [31:0] op2_p1;

    logic [15:0] cnt;
    logic [16:0] cnt_inc;
    logic        timed_out;

    function automatic logic is_mem(input logic [5:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // One extra bit keeps the compare correct when a completion at the limit
    // pushes a granted load into RESP with the count already at TIMEOUT_CYC.
    assign cnt_inc   = {1'b0, cnt} + 17'd1;
    assign timed_out = (cnt_inc >= 17'(TIMEOUT_CYC));

    assign stall = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            opc_p1     <= '0;
            alu_p1     <= '0;
            op2_p1     <= '0;
            cnt        <= '0;
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            wb_valid   <= 1'b0;
            wb_opcode  <= '0;
            wb_alu_out <= '0;
            wb_oprand2 <= '0;
            mem_out    <= '0;
            mem_err    <= 1'b0;
        end else begin
            // Retire indications are single-cycle pulses.
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;

            case (state)
                // ---- accept from execute ----
                IDLE: begin
                    if (ex_valid) begin
                        if (is_mem(ex_opcode) && (ex_alu_out[1:0] == 2'b00)) begin
                            opc_p1   <= ex_opcode;
                            alu_p1   <= ex_alu_out;
                            op2_p1   <= ex_oprand2;
                            cnt      <= '0;
                            dm_req   <= 1'b1;
                            dm_we    <= (ex_opcode == OP_ST);
                            dm_addr  <= ex_alu_out;
                            dm_wdata <= ex_oprand2;
                            state    <= REQ;
                        end else begin
                            // Non-memory op or misaligned access retires
                            // immediately without touching the bus.
                            wb_valid   <= 1'b1;
                            wb_opcode  <= ex_opcode;
                            wb_alu_out <= ex_alu_out;
                            wb_oprand2 <= ex_oprand2;
                            mem_out    <= '0;
                            mem_err    <= is_mem(ex_opcode);
                        end
                    end
                end

                // ---- bus request outstanding ----
                REQ: begin
                    cnt <= cnt_inc[15:0];
                    if (dm_gnt) begin
                        dm_req <= 1'b0;
                        dm_we  <= 1'b0;
                        if (opc_p1 == OP_ST) begin
                            wb_valid   <= 1'b1;
                            wb_opcode  <= opc_p1;
                            wb_alu_out <= alu_p1;
                            wb_oprand2 <= op2_p1;
                            mem_out    <= '0;
                            state      <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end else if (timed_out) begin
                        dm_req     <= 1'b0;
                        dm_we      <= 1'b0;
                        wb_valid   <= 1'b1;
                        mem_err    <= 1'b1;
                        wb_opcode  <= opc_p1;
                        wb_alu_out <= alu_p1;
                        wb_oprand2 <= op2_p1;
                        mem_out    <= '0;
                        state      <= IDLE;
                    end
                end

                // ---- waiting for load data ----
                RESP: begin
                    cnt <= cnt_inc[15:0];
                    if (dm_rvalid || timed_out) begin
                        // rvalid wins over a timeout reached in the same cycle.
                        wb_valid   <= 1'b1;
                        mem_err    <= !dm_rvalid;
                        wb_opcode  <= opc_p1;
                        wb_alu_out <= alu_p1;
                        wb_oprand2 <= op2_p1;
                        mem_out    <= dm_rvalid ? dm_rdata : 32'h0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    dm_req <= 1'b0;
                    dm_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam logic [5:0] OP_LD   = 6'h23;
    localparam logic [5:0] OP_ST   = 6'h2B;
    localparam logic [5:0] OP_ADDU = 6'h21;
    localparam logic [5:0] OP_MOV  = 6'h0A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_oprand2;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic [5:0]  wb_opcode;
    logic [31:0] wb_alu_out;
    logic [31:0] wb_oprand2;
    logic [31:0] mem_out;
    logic        mem_err;

    mem_stage #(.TIMEOUT_CYC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_alu_out (ex_alu_out),
        .ex_oprand2 (ex_oprand2),
        .stall      (stall),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .wb_valid   (wb_valid),
        .wb_opcode  (wb_opcode),
        .wb_alu_out (wb_alu_out),
        .wb_oprand2 (wb_oprand2),
        .mem_out    (mem_out),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] op2;
        logic [31:0] mem;
        logic        err;
    } wb_t;

    typedef struct packed {
        logic [15:0] len;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    wb_t  exp_wb[$];
    bus_t exp_bus[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic push_wb(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] op2,
                           input logic [31:0] mem, input logic err);
        wb_t w;
        w.op = op; w.alu = alu; w.op2 = op2; w.mem = mem; w.err = err;
        exp_wb.push_back(w);
    endtask

    task automatic push_bus(input int len, input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        bus_t b;
        b.len = 16'(len); b.addr = addr; b.we = we; b.wdata = we ? wdata : 32'h0;
        exp_bus.push_back(b);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for exactly one accepting edge; returns 1ns
    // into the cycle after the accept.
    task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] op2);
        ex_valid   = 1'b1;
        ex_opcode  = op;
        ex_alu_out = alu;
        ex_oprand2 = op2;
        tick();
        ex_valid   = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        ex_valid   = 1'b0;
        ex_opcode  = '0;
        ex_alu_out = '0;
        ex_oprand2 = '0;
        dm_gnt     = 1'b0;
        dm_rvalid  = 1'b0;
        dm_rdata   = '0;

        fork
            begin : monitor
                int          run;
                logic [31:0] a0;
                logic        we0;
                logic [31:0] wd0;
                wb_t         e;
                bus_t        b;
                run = 0;
                forever begin
                    @(negedge clk);
                    if (wb_valid) begin
                        if (exp_wb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL wb_unexpected got op %h alu %h mem %h exp no retire",
                                     wb_opcode, wb_alu_out, mem_out);
                        end else begin
                            e = exp_wb.pop_front();
                            check("wb_retire",
                                  128'({wb_opcode, wb_alu_out, wb_oprand2, mem_out, mem_err}),
                                  128'(e));
                        end
                    end
                    if (mem_err && !wb_valid) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_err_alone got 1 exp 0");
                    end
                    if (dm_req) begin
                        if (run == 0) begin
                            a0  = dm_addr;
                            we0 = dm_we;
                            wd0 = dm_wdata;
                        end else begin
                            check("dm_stable", 128'({dm_addr, dm_we, dm_wdata}), 128'({a0, we0, wd0}));
                        end
                        run++;
                    end else if (run > 0) begin
                        if (exp_bus.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL dm_unexpected got addr %h len %0d exp no request", a0, run);
                        end else begin
                            b = exp_bus.pop_front();
                            check("dm_txn", 128'({16'(run), a0, we0, (we0 ? wd0 : 32'h0)}), 128'(b));
                        end
                        run = 0;
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset_bus", 128'({dm_req, dm_we, dm_addr, dm_wdata, stall}), 128'(0));
        check("reset_wb", 128'({wb_valid, wb_opcode, wb_alu_out, wb_oprand2, mem_out, mem_err}), 128'(0));
        rst_n = 1'b1;
        tick();

        // ADDU: retires next cycle, never stalls
        push_wb(OP_ADDU, 32'h0000_1234, 32'h55, 32'h0, 1'b0);
        issue(OP_ADDU, 32'h0000_1234, 32'h55);
        check("addu_stall_n1", 128'(stall), 128'(0));
        tick();
        check("addu_stall_n2", 128'(stall), 128'(0));

        // Back-to-back non-memory ops, one per cycle
        push_wb(OP_MOV,  32'h1, 32'hBEEF_0001, 32'h0, 1'b0);
        push_wb(OP_ADDU, 32'h2, 32'hBEEF_0002, 32'h0, 1'b0);
        ex_valid = 1'b1; ex_opcode = OP_MOV;  ex_alu_out = 32'h1; ex_oprand2 = 32'hBEEF_0001;
        tick();
        check("b2b_stall", 128'(stall), 128'(0));
        ex_opcode = OP_ADDU; ex_alu_out = 32'h2; ex_oprand2 = 32'hBEEF_0002;
        tick();
        ex_valid = 1'b0;
        tick();

        // Stray bus responses in IDLE are ignored
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h0BAD_0BAD;
        tick();
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        check("stray_idle_stall", 128'(stall), 128'(0));

        // LD 0x100: grant after 2 wait cycles, rvalid one cycle later
        // (rvalid arrives on the same cycle the count hits the limit)
        push_bus(3, 32'h100, 1'b0, 32'h0);
        push_wb(OP_LD, 32'h100, 32'h77, 32'hDEAD_BEEF, 1'b0);
        issue(OP_LD, 32'h100, 32'h77);
        check("ld_stall_req", 128'({stall, dm_req, dm_we, dm_addr}), 128'({1'b1, 1'b1, 1'b0, 32'h100}));
        tick();
        tick();
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        check("ld_resp", 128'({stall, dm_req}), 128'({1'b1, 1'b0}));
        tick();
        dm_rvalid = 1'b0;
        check("ld_done_stall", 128'(stall), 128'(0));

        // ST 0x204 with immediate grant
        push_bus(1, 32'h204, 1'b1, 32'hA5A5_0001);
        push_wb(OP_ST, 32'h204, 32'hA5A5_0001, 32'h0, 1'b0);
        issue(OP_ST, 32'h204, 32'hA5A5_0001);
        check("st_bus", 128'({dm_req, dm_we, dm_wdata}), 128'({1'b1, 1'b1, 32'hA5A5_0001}));
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        check("st_done_stall", 128'(stall), 128'(0));

        // Misaligned LD and ST: no bus access, immediate error retire
        push_wb(OP_LD, 32'h102, 32'h0, 32'h0, 1'b1);
        issue(OP_LD, 32'h102, 32'h0);
        check("misal_ld", 128'({dm_req, stall}), 128'(0));
        push_wb(OP_ST, 32'h207, 32'h1111, 32'h0, 1'b1);
        issue(OP_ST, 32'h207, 32'h1111);
        check("misal_st", 128'({dm_req, stall}), 128'(0));
        tick();

        // LD never granted: 4 cycles of request, then error retire
        push_bus(4, 32'h300, 1'b0, 32'h0);
        push_wb(OP_LD, 32'h300, 32'h0, 32'h0, 1'b1);
        issue(OP_LD, 32'h300, 32'h0);
        repeat (3) tick();
        check("to_req_stall", 128'(stall), 128'(1));
        tick();
        check("to_req_idle", 128'(stall), 128'(0));
        push_wb(OP_MOV, 32'h9, 32'hCAFE, 32'h0, 1'b0);
        issue(OP_MOV, 32'h9, 32'hCAFE);
        tick();

        // LD granted immediately, rvalid never arrives: timeout in RESP
        push_bus(1, 32'h310, 1'b0, 32'h0);
        push_wb(OP_LD, 32'h310, 32'h0, 32'h0, 1'b1);
        issue(OP_LD, 32'h310, 32'h0);
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        tick();
        tick();
        check("to_resp_stall", 128'(stall), 128'(1));
        tick();
        check("to_resp_idle", 128'(stall), 128'(0));

        // Reset while in REQ: dm_req and stall drop asynchronously
        push_bus(2, 32'h500, 1'b0, 32'h0);
        issue(OP_LD, 32'h500, 32'h0);
        tick();
        #5;
        rst_n = 1'b0;
        #1;
        check("rst_req", 128'({dm_req, stall}), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while in RESP; a late rvalid must not produce a retire
        push_bus(1, 32'h600, 1'b0, 32'h0);
        issue(OP_LD, 32'h600, 32'h0);
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        check("rst_resp_pre", 128'({stall, dm_req}), 128'({1'b1, 1'b0}));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_resp_bus", 128'({dm_req, dm_we, dm_addr, dm_wdata, stall}), 128'(0));
        check("rst_resp_wb", 128'({wb_valid, wb_opcode, wb_alu_out, wb_oprand2, mem_out, mem_err}), 128'(0));
        tick();
        rst_n = 1'b1;
        dm_rvalid = 1'b1; dm_rdata = 32'h1234_5678;
        tick();
        dm_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_rvalid_wbv", 128'({wb_valid, stall}), 128'(0));
            tick();
        end

        // Normal operation after reset
        push_wb(OP_MOV, 32'h42, 32'h0000_00FF, 32'h0, 1'b0);
        issue(OP_MOV, 32'h42, 32'h0000_00FF);
        repeat (3) tick();

        check("wb_queue_empty", 128'(exp_wb.size()), 128'(0));
        check("bus_queue_empty", 128'(exp_bus.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
